// File: rtl/exec_run_controller_pkg.sv
// Shared definitions for the program-run controller: register index of the
// return value, result status codes and the run sequencer state encoding.
package exec_run_controller_pkg;

  // a0 holds the program's return value under the RISC-V calling convention
  localparam logic [4:0] REG_A0 = 5'd10;

  localparam logic [1:0] RUN_ST_HALT        = 2'b00;
  localparam logic [1:0] RUN_ST_TIMEOUT     = 2'b01;
  localparam logic [1:0] RUN_ST_HALT_NO_RET = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_REPORT = 2'd3
  } run_state_e;

  // A halt only counts as a clean return if a0 was written at some point
  function automatic logic [1:0] halt_status(input logic ret_written);
    return ret_written ? RUN_ST_HALT : RUN_ST_HALT_NO_RET;
  endfunction

endpackage

// File: rtl/exec_run_controller_run_cycle_timer.sv
// Saturating run-cycle counter with a limit compare. A limit of zero means
// the timer never expires; expire_next flags that the current cycle is the
// last one allowed by the limit.
module exec_run_controller_run_cycle_timer #(
  parameter int unsigned CYC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CYC_W-1:0] limit,
  output logic [CYC_W-1:0] count,
  output logic             expire_next
);

  logic [CYC_W-1:0] count_q;
  logic [CYC_W-1:0] count_d;

  // Next count: clear wins, otherwise count up and stick at all-ones
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + CYC_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Extended-width compare so a saturated count cannot wrap into a false match
  always_comb begin
    expire_next = (limit != '0) &&
                  (({1'b0, count_q} + (CYC_W + 1)'(1)) == {1'b0, limit});
  end

  assign count = count_q;

endmodule

// File: rtl/exec_run_controller.sv
// Sequences one program run on the core: holds core reset, lets the core run
// while snooping write-back for the return register, stops on halt or
// timeout and presents {value, status, cycles} on a valid/ready channel.
module exec_run_controller
  import exec_run_controller_pkg::*;
#(
  parameter logic [4:0]  RET_REG    = REG_A0,
  parameter int unsigned RESET_HOLD = 4,
  parameter int unsigned CYC_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [CYC_W-1:0] timeout_cycles,
  output logic             core_rst_n,
  input  logic             halt_req,
  input  logic [4:0]       rd_addr,
  input  logic [31:0]      rd_value,
  input  logic             rd_write_enable,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_value,
  output logic [1:0]       res_status,
  output logic [CYC_W-1:0] res_cycles
);

  localparam int unsigned     HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  run_state_e state_q, state_d;

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CYC_W-1:0]  timeout_q, timeout_d;
  logic              ret_seen_q, ret_seen_d;
  logic [31:0]       ret_val_q, ret_val_d;
  logic [31:0]       res_value_q, res_value_d;
  logic [1:0]        res_status_q, res_status_d;
  logic [CYC_W-1:0]  res_cycles_q, res_cycles_d;

  logic             start_fire;
  logic             in_run;
  logic             ret_write;
  logic             run_done;
  logic [CYC_W-1:0] run_count;
  logic [CYC_W-1:0] run_count_inc;
  logic             expire_next;

  assign start_fire    = start_valid && start_ready;
  assign in_run        = (state_q == ST_RUN);
  assign ret_write     = in_run && rd_write_enable && (rd_addr == RET_REG);
  assign run_done      = in_run && (halt_req || expire_next);
  assign run_count_inc = (run_count == '1) ? run_count : run_count + CYC_W'(1);

  exec_run_controller_run_cycle_timer #(
    .CYC_W(CYC_W)
  ) u_run_cycle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_fire),
    .enable     (in_run),
    .limit      (timeout_q),
    .count      (run_count),
    .expire_next(expire_next)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE -> HOLD -> RUN -> REPORT -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_fire) state_d = ST_HOLD;
      ST_HOLD:   if (hold_cnt_q == HOLD_LAST) state_d = ST_RUN;
      ST_RUN:    if (halt_req || expire_next) state_d = ST_REPORT;
      ST_REPORT: if (res_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Handshake and core reset outputs, all forced quiet while rst_n is low
  always_comb begin
    start_ready = 1'b0;
    core_rst_n  = 1'b0;
    res_valid   = 1'b0;
    case (state_q)
      ST_IDLE:   start_ready = rst_n;
      ST_RUN:    core_rst_n  = rst_n;
      ST_REPORT: res_valid   = rst_n;
      default:   ;
    endcase
  end

  // Hold counter, run capture and result updates at start accept / run end
  always_comb begin
    hold_cnt_d   = (state_q == ST_HOLD) ? hold_cnt_q + HOLD_W'(1) : '0;
    timeout_d    = timeout_q;
    ret_seen_d   = ret_seen_q;
    ret_val_d    = ret_val_q;
    res_value_d  = res_value_q;
    res_status_d = res_status_q;
    res_cycles_d = res_cycles_q;

    if (start_fire) begin
      timeout_d    = timeout_cycles;
      ret_seen_d   = 1'b0;
      ret_val_d    = '0;
      res_value_d  = '0;
      res_status_d = RUN_ST_HALT;
      res_cycles_d = '0;
    end

    if (ret_write) begin
      ret_val_d  = rd_value;
      ret_seen_d = 1'b1;
    end

    if (run_done) begin
      res_value_d  = ret_write ? rd_value : ret_val_q;
      res_cycles_d = run_count_inc;
      res_status_d = halt_req ? halt_status(ret_seen_q || ret_write) : RUN_ST_TIMEOUT;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_q   <= '0;
      timeout_q    <= '0;
      ret_seen_q   <= 1'b0;
      ret_val_q    <= '0;
      res_value_q  <= '0;
      res_status_q <= RUN_ST_HALT;
      res_cycles_q <= '0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      timeout_q    <= timeout_d;
      ret_seen_q   <= ret_seen_d;
      ret_val_q    <= ret_val_d;
      res_value_q  <= res_value_d;
      res_status_q <= res_status_d;
      res_cycles_q <= res_cycles_d;
    end
  end

  assign res_value  = res_value_q;
  assign res_status = res_status_q;
  assign res_cycles = res_cycles_q;

endmodule

// File: tb/tb_exec_run_controller.sv
// Testbench for exec_run_controller: scripted program runs against a small
// behavioural model, with expected results queued at start and checked when
// the controller reports.
module tb_exec_run_controller;

  localparam int CYC_W      = 32;
  localparam int RESET_HOLD = 4;

  typedef struct {
    int          tmo;
    int          halt;
    int          w1c;
    logic [4:0]  w1a;
    logic [31:0] w1v;
    int          w2c;
    logic [4:0]  w2a;
    logic [31:0] w2v;
  } run_cfg_t;

  typedef struct {
    logic [31:0] value;
    logic [1:0]  status;
    logic [31:0] cycles;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [CYC_W-1:0] timeout_cycles = '0;
  logic             core_rst_n;
  logic             halt_req = 1'b0;
  logic [4:0]       rd_addr = '0;
  logic [31:0]      rd_value = '0;
  logic             rd_write_enable = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [31:0]      res_value;
  logic [1:0]       res_status;
  logic [CYC_W-1:0] res_cycles;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  exec_run_controller #(
    .RET_REG   (5'd10),
    .RESET_HOLD(RESET_HOLD),
    .CYC_W     (CYC_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_valid    (start_valid),
    .start_ready    (start_ready),
    .timeout_cycles (timeout_cycles),
    .core_rst_n     (core_rst_n),
    .halt_req       (halt_req),
    .rd_addr        (rd_addr),
    .rd_value       (rd_value),
    .rd_write_enable(rd_write_enable),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_value      (res_value),
    .res_status     (res_status),
    .res_cycles     (res_cycles)
  );

  always #5 clk = ~clk;

  // Reference behaviour of one run, cycle by cycle from RUN cycle 1
  function automatic exp_t model(input run_cfg_t cfg);
    exp_t e;
    logic seen;
    e.value  = '0;
    e.status = 2'b11;
    e.cycles = '0;
    seen     = 1'b0;
    for (int c = 1; c <= 5000; c++) begin
      if (c == cfg.w1c && cfg.w1a == 5'd10) begin e.value = cfg.w1v; seen = 1'b1; end
      if (c == cfg.w2c && cfg.w2a == 5'd10) begin e.value = cfg.w2v; seen = 1'b1; end
      if (c == cfg.halt) begin
        e.status = seen ? 2'b00 : 2'b10;
        e.cycles = c;
        return e;
      end
      if (cfg.tmo != 0 && c == cfg.tmo) begin
        e.status = 2'b01;
        e.cycles = c;
        return e;
      end
    end
    return e;
  endfunction

  // Start one run, drive its core activity, check the report, then accept it
  // after holding res_ready low for hold_ready cycles
  task automatic run_program(input string name, input run_cfg_t cfg, input int hold_ready);
    exp_t        e;
    int          hold_len;
    int          cyc;
    bit          got;
    logic [31:0] v0;
    logic [1:0]  s0;
    logic [31:0] c0;
    exp_q.push_back(model(cfg));

    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s start_ready: got %b want 1", name, start_ready);
    end
    start_valid    = 1'b1;
    timeout_cycles = cfg.tmo;
    @(negedge clk);
    start_valid = 1'b0;

    hold_len = 0;
    while (core_rst_n !== 1'b1 && hold_len < 20) begin
      hold_len++;
      @(negedge clk);
    end
    checks++;
    if (hold_len != RESET_HOLD) begin
      errors++;
      $display("[TB] FAIL %s hold_len: got %0d want %0d", name, hold_len, RESET_HOLD);
    end

    cyc = 0;
    got = 1'b0;
    for (int g = 0; g < 2000 && !got; g++) begin
      halt_req        = 1'b0;
      rd_write_enable = 1'b0;
      rd_addr         = '0;
      rd_value        = '0;
      if (res_valid === 1'b1) begin
        got = 1'b1;
      end else begin
        if (core_rst_n === 1'b1) begin
          cyc++;
          if (cyc == cfg.halt) halt_req = 1'b1;
          if (cyc == cfg.w1c) begin rd_write_enable = 1'b1; rd_addr = cfg.w1a; rd_value = cfg.w1v; end
          if (cyc == cfg.w2c) begin rd_write_enable = 1'b1; rd_addr = cfg.w2a; rd_value = cfg.w2v; end
        end
        @(negedge clk);
      end
    end

    e = exp_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL %s result: no res_valid within budget, want value %h status %b cycles %0d",
               name, e.value, e.status, e.cycles);
      return;
    end
    if (res_value !== e.value || res_status !== e.status || res_cycles !== e.cycles) begin
      errors++;
      $display("[TB] FAIL %s result: got value %h status %b cycles %0d want value %h status %b cycles %0d",
               name, res_value, res_status, res_cycles, e.value, e.status, e.cycles);
    end
    checks++;
    if (core_rst_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s core_rst_n in REPORT: got %b want 0", name, core_rst_n);
    end

    v0 = res_value;
    s0 = res_status;
    c0 = res_cycles;
    for (int i = 0; i < hold_ready; i++) begin
      res_ready   = 1'b0;
      start_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || start_ready !== 1'b0 || res_value !== v0 ||
          res_status !== s0 || res_cycles !== c0) begin
        errors++;
        $display("[TB] FAIL %s stall %0d: got valid %b ready %b value %h status %b cycles %0d want 1 0 %h %b %0d",
                 name, i, res_valid, start_ready, res_value, res_status, res_cycles, v0, s0, c0);
      end
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1 || res_value !== v0 ||
        res_status !== s0 || res_cycles !== c0) begin
      errors++;
      $display("[TB] FAIL %s after accept: got valid %b ready %b value %h status %b cycles %0d want 0 1 %h %b %0d",
               name, res_valid, start_ready, res_value, res_status, res_cycles, v0, s0, c0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (core_rst_n !== 1'b0 || start_ready !== 1'b0 || res_valid !== 1'b0 ||
        res_value !== 32'h0 || res_status !== 2'b00 || res_cycles !== '0) begin
      errors++;
      $display("[TB] FAIL reset: got core %b ready %b valid %b value %h status %b cycles %0d want 0 0 0 0 00 0",
               core_rst_n, start_ready, res_valid, res_value, res_status, res_cycles);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || core_rst_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset release: got ready %b core %b want 1 0", start_ready, core_rst_n);
    end
  endtask

  task automatic test_halt_with_ret();
    run_cfg_t cfg = '{100, 20, 5, 5'd10, 32'h2A, 0, 5'd0, 32'h0};
    run_program("halt_ret", cfg, 0);
  endtask

  task automatic test_timeout();
    run_cfg_t cfg = '{50, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0};
    run_program("timeout", cfg, 0);
  endtask

  task automatic test_coincident_write();
    run_cfg_t cfg_a = '{0, 10, 10, 5'd10, 32'hDEADBEEF, 0, 5'd0, 32'h0};
    run_cfg_t cfg_b = '{0, 10, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0};
    run_program("coincident", cfg_a, 0);
    run_program("no_ret", cfg_b, 0);
  endtask

  task automatic test_halt_timeout_tie();
    run_cfg_t cfg = '{30, 30, 3, 5'd10, 32'h1234, 30, 5'd11, 32'h9999};
    run_program("tie", cfg, 0);
  endtask

  task automatic test_last_write();
    run_cfg_t cfg = '{0, 9, 2, 5'd10, 32'h11, 7, 5'd10, 32'h22};
    run_program("last_write", cfg, 0);
  endtask

  task automatic test_back_to_back();
    run_cfg_t cfg_a = '{0, 6, 1, 5'd10, 32'h55AA55AA, 4, 5'd11, 32'h1};
    run_cfg_t cfg_b = '{12, 0, 4, 5'd10, 32'h77, 0, 5'd0, 32'h0};
    run_program("stall", cfg_a, 10);
    run_program("second", cfg_b, 0);
  endtask

  task automatic test_stray_halt();
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1 || core_rst_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stray_halt: got valid %b ready %b core %b want 0 1 0",
               res_valid, start_ready, core_rst_n);
    end
  endtask

  task automatic test_reset_mid_run();
    int  guard;
    bit  saw_valid;
    start_valid    = 1'b1;
    timeout_cycles = '0;
    @(negedge clk);
    start_valid = 1'b0;
    guard = 0;
    while (core_rst_n !== 1'b1 && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (core_rst_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrun core_rst_n before reset: got %b want 1", core_rst_n);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (core_rst_n !== 1'b0 || res_valid !== 1'b0 || start_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrun reset: got core %b valid %b ready %b want 0 0 0",
               core_rst_n, res_valid, start_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || core_rst_n !== 1'b0 || res_cycles !== '0) begin
      errors++;
      $display("[TB] FAIL midrun idle: got ready %b core %b cycles %0d want 1 0 0",
               start_ready, core_rst_n, res_cycles);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid) begin
      errors++;
      $display("[TB] FAIL midrun no_result: got res_valid 1 want 0");
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_halt_with_ret();
    test_timeout();
    test_coincident_write();
    test_halt_timeout_tie();
    test_last_write();
    test_back_to_back();
    test_stray_halt();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
